// File: rtl/test_result_monitor.sv
// test_result_monitor
// Snoops the register-file write-back port, shadows the test-number and
// result registers, detects end-of-test, waits a settle window and then
// holds a sticky PASS / FAIL / TIMEOUT verdict until reset.
module test_result_monitor #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DONE_REG       = 26,
    parameter int RESULT_REG     = 27,
    parameter int TESTNUM_REG    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] fail_test_num,
    output logic [31:0] cycle_count
);

    localparam logic [4:0]  DONE_IDX     = 5'(DONE_REG);
    localparam logic [4:0]  RESULT_IDX   = 5'(RESULT_REG);
    localparam logic [4:0]  TESTNUM_IDX  = 5'(TESTNUM_REG);
    localparam logic [7:0]  SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    state_t      state_reg;
    logic [7:0]  settle_cnt_reg;
    logic [31:0] result_shadow_reg;
    logic [31:0] testnum_shadow_reg;

    logic        wr_valid;
    logic        done_hit;
    logic        active;
    logic [31:0] count_next;

    // Decode the snooped write; x0 never counts as a write.
    always_comb begin
        wr_valid   = wb_we && (wb_waddr != 5'd0);
        done_hit   = wr_valid && (wb_waddr == DONE_IDX) && (wb_wdata == 32'h1);
        active     = (state_reg == ST_RUN) || (state_reg == ST_SETTLE);
        count_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    end

    // Shadow copies of the result and test-number registers; frozen once a
    // verdict is reached. The done flag itself is acted on straight from the
    // write port, so it needs no stored copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_shadow_reg  <= 32'd0;
            testnum_shadow_reg <= 32'd0;
        end else if (active && wr_valid) begin
            if (wb_waddr == RESULT_IDX)
                result_shadow_reg <= wb_wdata;
            if (wb_waddr == TESTNUM_IDX)
                testnum_shadow_reg <= wb_wdata;
        end
    end

    // Verdict FSM with registered status outputs and elapsed-cycle counter.
    // The edge that enters a terminal state does not advance cycle_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            settle_cnt_reg <= 8'd0;
            cycle_count    <= 32'd0;
            fail_test_num  <= 32'd0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (done_hit) begin
                        // done wins over a coincident timeout
                        state_reg      <= ST_SETTLE;
                        settle_cnt_reg <= SETTLE_LOAD;
                        cycle_count    <= count_next;
                    end else if (cycle_count == TIMEOUT_LAST) begin
                        state_reg     <= ST_TIMEOUT;
                        fail_test_num <= testnum_shadow_reg;
                        done          <= 1'b1;
                        timeout       <= 1'b1;
                    end else begin
                        cycle_count <= count_next;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_reg == 8'd0) begin
                        // verdict uses the stored result, not a same-cycle write
                        fail_test_num <= testnum_shadow_reg;
                        done          <= 1'b1;
                        if (result_shadow_reg == 32'h1) begin
                            state_reg <= ST_PASS;
                            pass      <= 1'b1;
                        end else begin
                            state_reg <= ST_FAIL;
                            fail      <= 1'b1;
                        end
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 8'd1;
                        cycle_count    <= count_next;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_reg <= state_reg;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor (SETTLE_CYCLES=2, TIMEOUT_CYCLES=50).
// Inputs change just after the falling edge; outputs are checked there too.
module tb_test_result_monitor;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] fail_test_num;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    test_result_monitor #(
        .SETTLE_CYCLES (2),
        .TIMEOUT_CYCLES(50),
        .DONE_REG      (26),
        .RESULT_REG    (27),
        .TESTNUM_REG   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_we        (wb_we),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .fail_test_num(fail_test_num),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // status = {done, pass, fail, timeout}
    task automatic check_all(input string tag, input logic [3:0] st,
                             input logic [31:0] ftn, input logic [31:0] cnt);
        check({tag, ".status"}, {28'd0, done, pass, fail, timeout}, {28'd0, st});
        check({tag, ".ftn"}, fail_test_num, ftn);
        check({tag, ".count"}, cycle_count, cnt);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        @(negedge clk);
        wb_we    = 1'b0;
        $display("write x%0d = %0h  -> done=%0b pass=%0b fail=%0b timeout=%0b cnt=%0d",
                 a, d, done, pass, fail, timeout, cycle_count);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset applied");
    endtask

    initial begin
        rst      = 1'b1;
        wb_we    = 1'b0;
        wb_waddr = 5'd0;
        wb_wdata = 32'd0;
        @(negedge clk);

        // reset state
        do_reset();
        check_all("reset", 4'b0000, 32'd0, 32'd0);

        // pass sequence: done write in cycle 10
        wr(5'd3, 32'd5);
        wr(5'd27, 32'd1);
        tick(8);
        check("pass.pre_count", cycle_count, 32'd10);
        wr(5'd26, 32'd1);
        check_all("pass.settle1", 4'b0000, 32'd0, 32'd11);
        tick(1);
        check_all("pass.settle2", 4'b0000, 32'd0, 32'd12);
        tick(1);
        check_all("pass.verdict", 4'b1100, 32'd5, 32'd12);
        tick(3);
        check_all("pass.sticky", 4'b1100, 32'd5, 32'd12);

        // fail sequence, sticky against later writes
        do_reset();
        check_all("fail.reset", 4'b0000, 32'd0, 32'd0);
        wr(5'd3, 32'd7);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        tick(2);
        check_all("fail.verdict", 4'b1010, 32'd7, 32'd4);
        wr(5'd27, 32'd1);
        wr(5'd3, 32'd9);
        tick(98);
        check_all("fail.sticky", 4'b1010, 32'd7, 32'd4);

        // result written inside the settle window is honoured
        do_reset();
        wr(5'd26, 32'd1);
        wr(5'd27, 32'd1);
        tick(1);
        check_all("late.pass", 4'b1100, 32'd0, 32'd2);

        // result written on the verdict edge itself is not considered
        do_reset();
        wr(5'd26, 32'd1);
        tick(1);
        wr(5'd27, 32'd1);
        check_all("lastedge.fail", 4'b1010, 32'd0, 32'd2);

        // non-1 done value and x0 writes cause no transition
        do_reset();
        wr(5'd26, 32'd2);
        tick(3);
        check_all("done2.none", 4'b0000, 32'd0, 32'd4);
        wr(5'd0, 32'd1);
        tick(2);
        check_all("x0.none", 4'b0000, 32'd0, 32'd7);
        wr(5'd26, 32'd1);
        tick(2);
        check_all("x0.fail", 4'b1010, 32'd0, 32'd9);

        // timeout after the 50th cycle with count frozen at 49
        do_reset();
        wr(5'd3, 32'd11);
        tick(48);
        check_all("to.before", 4'b0000, 32'd0, 32'd49);
        tick(1);
        check_all("to.hit", 4'b1001, 32'd11, 32'd49);
        tick(5);
        check_all("to.frozen", 4'b1001, 32'd11, 32'd49);

        // done write coincident with the timeout condition: done wins
        do_reset();
        wr(5'd27, 32'd1);
        tick(48);
        check_all("sim.before", 4'b0000, 32'd0, 32'd49);
        wr(5'd26, 32'd1);
        check_all("sim.settle", 4'b0000, 32'd0, 32'd50);
        tick(1);
        check_all("sim.settle2", 4'b0000, 32'd0, 32'd51);
        tick(1);
        check_all("sim.pass", 4'b1100, 32'd0, 32'd51);

        // reset during SETTLE
        do_reset();
        wr(5'd3, 32'd4);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        do_reset();
        check_all("rst.settle", 4'b0000, 32'd0, 32'd0);
        tick(2);
        check_all("rst.settle_run", 4'b0000, 32'd0, 32'd2);
        wr(5'd3, 32'd5);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        tick(2);
        check_all("rst.pass1", 4'b1100, 32'd5, 32'd6);

        // reset in PASS, then a fresh pass sequence
        do_reset();
        check_all("rst.pass", 4'b0000, 32'd0, 32'd0);
        wr(5'd3, 32'd6);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        tick(2);
        check_all("rst.pass2", 4'b1100, 32'd6, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
